echo_counter: RTL and testbench

//  Front end of the ultrasonic ranging chain, feeding the divisor block downstream.
//  - Fires the sensor trigger pulse.
//  - Measures the echo pulse width in ticks of TICK_DIV clocks.
//  - Presents the result on count with a one-cycle calculate strobe, which the divisor consumes.
//  - Repeats every measurement cycle while enable is high.

---
 rtl/ultrasonido_pkg.sv | 27 ++
 rtl/echo_sync.sv | 32 +++
 rtl/echo_counter.sv | 156 +++++++++++++++
 tb/tb_echo_counter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonido_pkg.sv
// Shared definitions for the ultrasonic ranging chain: FSM state type and default timing.
// The divisor block imports the same defaults so both ends agree on count width.
package ultrasonido_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StDone,
        StHoldoff
    } state_e;

    localparam int unsigned DefCountW      = 8;
    localparam int unsigned DefTrigCycles  = 10;
    localparam int unsigned DefTickDiv     = 58;
    localparam int unsigned DefWaitTimeout = 30000;
    localparam int unsigned DefHoldoff     = 60000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Brings the asynchronous echo pin into the clock domain and produces one-cycle
// registered rise/fall pulses, three cycles after the pin moves.
module echo_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q, rise_q, fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/echo_counter.sv
// Ultrasonic ranging front end: fires the trigger, measures echo width in ticks and
// hands the result to the divisor with a one-cycle calculate strobe.
module echo_counter
    import ultrasonido_pkg::*;
#(
    parameter int unsigned COUNT_W      = DefCountW,
    parameter int unsigned TRIG_CYCLES  = DefTrigCycles,
    parameter int unsigned TICK_DIV     = DefTickDiv,
    parameter int unsigned WAIT_TIMEOUT = DefWaitTimeout,
    parameter int unsigned HOLDOFF      = DefHoldoff
) (
    input  logic               CLKOUTD,
    input  logic               reset,
    input  logic               enable,
    input  logic               echo,
    output logic               trigger,
    output logic [COUNT_W-1:0] count,
    output logic               calculate,
    output logic               timeout,
    output logic               busy
);

    localparam int unsigned CycMax = max3(TRIG_CYCLES, WAIT_TIMEOUT, HOLDOFF);
    localparam int unsigned CycW   = $clog2(CycMax + 1);
    localparam int unsigned TickW  = $clog2(TICK_DIV + 1);

    state_e               state_q, state_d;
    logic [CycW-1:0]      cyc_q, cyc_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [COUNT_W-1:0]   width_q, width_d;
    logic                 to_q, to_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 timeout_q, timeout_d;
    logic                 calculate_q, calculate_d;
    logic                 echo_rise, echo_fall;
    logic                 tick_wrap, sat;

    echo_sync u_echo_sync (
        .clk_i  (CLKOUTD),
        .rst_i  (reset),
        .echo_i (echo),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    always_ff @(posedge CLKOUTD or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cyc_q       <= '0;
            tick_q      <= '0;
            width_q     <= '0;
            to_q        <= 1'b0;
            count_q     <= '0;
            timeout_q   <= 1'b0;
            calculate_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            tick_q      <= tick_d;
            width_q     <= width_d;
            to_q        <= to_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
            calculate_q <= calculate_d;
        end
    end

    assign tick_wrap = (tick_q == TickW'(TICK_DIV - 1));
    assign sat       = tick_wrap && (width_q == '1);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tick_d  = tick_q;
        width_d = width_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StTrig;
                    cyc_d   = '0;
                end
            end
            StTrig: begin
                if (cyc_q == CycW'(TRIG_CYCLES - 1)) begin
                    state_d = StWaitRise;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StWaitRise: begin
                // A level already high here produces no rise pulse, so it times out.
                if (echo_rise) begin
                    state_d = StMeasure;
                    tick_d  = '0;
                    width_d = '0;
                    to_d    = 1'b0;
                end else if (cyc_q == CycW'(WAIT_TIMEOUT - 1)) begin
                    state_d = StDone;
                    width_d = '0;
                    to_d    = 1'b1;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StMeasure: begin
                tick_d = tick_wrap ? '0 : tick_q + TickW'(1);
                if (tick_wrap && !sat) begin
                    width_d = width_q + COUNT_W'(1);
                end
                if (sat) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                end else if (echo_fall) begin
                    state_d = StDone;
                    to_d    = 1'b0;
                end
            end
            StDone: begin
                state_d = StHoldoff;
                cyc_d   = '0;
            end
            StHoldoff: begin
                if (cyc_q == CycW'(HOLDOFF - 1)) begin
                    state_d = enable ? StTrig : StIdle;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result registers move only in DONE, so the strobe always accompanies new data.
    always_comb begin
        count_d     = count_q;
        timeout_d   = timeout_q;
        calculate_d = 1'b0;
        if (state_q == StDone) begin
            count_d     = width_q;
            timeout_d   = to_q;
            calculate_d = 1'b1;
        end
    end

    always_comb begin
        trigger   = (state_q == StTrig);
        busy      = (state_q != StIdle);
        count     = count_q;
        timeout   = timeout_q;
        calculate = calculate_q;
    end

endmodule

// File: tb/tb_echo_counter.sv
// Self-checking bench for echo_counter: vector table, random runs against a reference
// model, and hand sequences for continuous run, enable drop and mid-measurement reset.
module tb_echo_counter;

    localparam int TRIG = 4;
    localparam int TICK = 2;
    localparam int WT   = 16;
    localparam int HO   = 8;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          CLKOUTD = 1'b0;
    logic          reset;
    logic          enable;
    logic          echo;
    logic          trigger;
    logic [CW-1:0] count;
    logic          calculate;
    logic          timeout;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    bit watch_busy = 1'b0;
    int busy_low = 0;
    int stable_viol = 0;
    logic [CW-1:0] prev_count = '0;
    logic          prev_to = 1'b0;

    typedef struct {
        int d;
        int len;
        int exp_c;
        int exp_t;
    } vec_t;

    vec_t vecs[10];

    echo_counter #(
        .COUNT_W      (CW),
        .TRIG_CYCLES  (TRIG),
        .TICK_DIV     (TICK),
        .WAIT_TIMEOUT (WT),
        .HOLDOFF      (HO)
    ) dut (
        .CLKOUTD   (CLKOUTD),
        .reset     (reset),
        .enable    (enable),
        .echo      (echo),
        .trigger   (trigger),
        .count     (count),
        .calculate (calculate),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 CLKOUTD = ~CLKOUTD;

    always @(posedge CLKOUTD) cyc_cnt <= cyc_cnt + 1;

    always @(negedge CLKOUTD) begin
        if (watch_busy && !busy) busy_low <= busy_low + 1;
        if (!reset && !calculate && (count !== prev_count || timeout !== prev_to))
            stable_viol <= stable_viol + 1;
        prev_count <= count;
        prev_to    <= timeout;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLKOUTD);
        #1;
    endtask

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    // Reference: width floors to whole ticks, saturates one tick past max, and the strobe
    // appears sync latency (3) + done/strobe (2) cycles after the echo ends.
    function automatic void ref_meas(input int d, input int len, output int c, output int t,
                                     output int k);
        if (len == 0 || d + 3 > WT - 1) begin
            c = 0;
            t = 1;
            k = WT + 1;
        end else if (len / TICK > MAXC) begin
            c = MAXC;
            t = 1;
            k = d + 5 + (MAXC + 1) * TICK;
        end else begin
            c = len / TICK;
            t = 0;
            k = d + 5 + len;
        end
    endfunction

    // drop_k < 0 drops enable during trigger; otherwise enable drops at cycle drop_k
    // after the trigger falls.
    task automatic run_meas(input int d, input int len, input int drop_k,
                            output int c, output int t, output int kcal, output int ncal,
                            output int tw, output int abs_cal);
        int guard;
        guard   = 0;
        c       = 0;
        t       = 0;
        kcal    = -1;
        ncal    = 0;
        tw      = 0;
        abs_cal = 0;
        enable  = 1'b1;
        while (!trigger && guard < 300) begin
            step();
            guard++;
        end
        while (trigger && tw < 50) begin
            tw++;
            if (drop_k < 0) enable = 1'b0;
            step();
        end
        for (int k = 0; k < 1500; k++) begin
            echo = (k >= d) && (k < d + len);
            if (k == drop_k) enable = 1'b0;
            if (calculate) begin
                ncal++;
                if (ncal == 1) begin
                    kcal    = k;
                    c       = int'(count);
                    t       = int'(timeout);
                    abs_cal = cyc_cnt;
                end
            end
            if (ncal > 0 && k >= d + len + 2) break;
            step();
        end
        echo = 1'b0;
    endtask

    task automatic wait_idle(input int idx);
        int g;
        int n;
        g = 0;
        n = 0;
        while (busy && g < 60) begin
            step();
            g++;
        end
        check("idle_reached", idx, int'(busy), 0);
        for (int i = 0; i < 12; i++) begin
            if (trigger || busy) n++;
            step();
        end
        check("parked", idx, n, 0);
    endtask

    task automatic do_vec(input int idx, input int d, input int len, input int exp_c,
                          input int exp_t, input int drop_k);
        int c, t, kcal, ncal, tw, abs_cal, rc, rt, rk;
        ref_meas(d, len, rc, rt, rk);
        run_meas(d, len, drop_k, c, t, kcal, ncal, tw, abs_cal);
        check("trig_width", idx, tw, TRIG);
        check("strobe_count", idx, ncal, 1);
        check("count", idx, c, exp_c);
        check("timeout", idx, t, exp_t);
        check("strobe_latency", idx, kcal, rk);
        wait_idle(idx);
    endtask

    initial begin
        int c, t, kcal, ncal, tw, abs_cal, prev_abs, rc, rt, rk, d, len, n;

        vecs[0] = '{d: 0,  len: 86,  exp_c: 43,  exp_t: 0};
        vecs[1] = '{d: 3,  len: 0,   exp_c: 0,   exp_t: 1};
        vecs[2] = '{d: 12, len: 6,   exp_c: 3,   exp_t: 0};
        vecs[3] = '{d: 13, len: 6,   exp_c: 0,   exp_t: 1};
        vecs[4] = '{d: 1,  len: 1,   exp_c: 0,   exp_t: 0};
        vecs[5] = '{d: 2,  len: 3,   exp_c: 1,   exp_t: 0};
        vecs[6] = '{d: 0,  len: 600, exp_c: 255, exp_t: 1};
        vecs[7] = '{d: 5,  len: 511, exp_c: 255, exp_t: 0};
        vecs[8] = '{d: 5,  len: 512, exp_c: 255, exp_t: 1};
        vecs[9] = '{d: 4,  len: 2,   exp_c: 1,   exp_t: 0};

        reset  = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        step();
        step();
        check("rst_trigger", 0, int'(trigger), 0);
        check("rst_count", 0, int'(count), 0);
        check("rst_calculate", 0, int'(calculate), 0);
        check("rst_timeout", 0, int'(timeout), 0);
        check("rst_busy", 0, int'(busy), 0);
        reset = 1'b0;
        step();

        foreach (vecs[i])
            do_vec(i, vecs[i].d, vecs[i].len, vecs[i].exp_c, vecs[i].exp_t, -1);

        for (int i = 0; i < 12; i++) begin
            d   = (($urandom % 5) == 0) ? int'($urandom_range(13, 15)) :
                                         int'($urandom_range(0, 12));
            len = (($urandom % 6) == 0) ? 0 : int'($urandom_range(1, 130));
            ref_meas(d, len, rc, rt, rk);
            do_vec(100 + i, d, len, rc, rt, -1);
        end

        // Back-to-back measurements with enable held high.
        prev_abs = 0;
        for (int i = 0; i < 3; i++) begin
            run_meas(2, 20, 1000000, c, t, kcal, ncal, tw, abs_cal);
            check("cont_count", i, c, 10);
            check("cont_timeout", i, t, 0);
            if (i > 0) check("cont_spacing", i, abs_cal - prev_abs, TRIG + 2 + 5 + 20 + HO);
            prev_abs   = abs_cal;
            watch_busy = 1'b1;
        end
        watch_busy = 1'b0;
        enable     = 1'b0;
        wait_idle(200);
        check("cont_busy_low", 0, busy_low, 0);

        // Enable drops while the echo is being measured.
        do_vec(300, 1, 40, 20, 0, 9);

        // Reset ten cycles into the echo.
        enable = 1'b1;
        n = 0;
        while (!trigger && n < 50) begin
            step();
            n++;
        end
        while (trigger && n < 100) begin
            step();
            n++;
        end
        enable = 1'b0;
        for (int k = 0; k < 12; k++) begin
            echo = (k >= 2);
            step();
        end
        check("pre_reset_busy", 400, int'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_trigger", 400, int'(trigger), 0);
        check("mid_rst_count", 400, int'(count), 0);
        check("mid_rst_calculate", 400, int'(calculate), 0);
        check("mid_rst_timeout", 400, int'(timeout), 0);
        check("mid_rst_busy", 400, int'(busy), 0);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (calculate) n++;
        end
        echo  = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (calculate || busy) n++;
            step();
        end
        check("mid_rst_quiet", 400, n, 0);
        do_vec(401, 0, 30, 15, 0, -1);

        check("count_stable", 0, stable_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
